// File: rtl/led_status_arbiter.sv
// Fixed-priority owner of the two status LEDs: grants one of four requesters,
// plays its latched blink pattern paced by a free-running prescaler.
module led_status_arbiter #(
  parameter int TICK_CYCLES = 262144,
  parameter int MIN_HOLD    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_req,
  input  logic [7:0] i_pattern,
  output logic [3:0] o_grant,
  output logic       o_busy,
  output logic       o_tick,
  output logic [1:0] o_LED
);

  localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e        state;
  logic [PW-1:0] pre_cnt;
  logic [1:0]    pat;
  logic [1:0]    step;
  logic [HW-1:0] hold;
  logic [1:0]    lit;
  logic [1:0]    win_idx;
  logic          owner_req;
  logic          higher_req;

  // Lower index wins, so scan from the top and let the last hit stick.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign o_tick     = (pre_cnt == TICK_MAX);
  assign win_idx    = lowest_idx(i_req);
  assign owner_req  = |(i_req & o_grant);
  assign higher_req = |(i_req & (o_grant - 4'd1));

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pre_cnt <= '0;
      o_grant <= 4'b0000;
      pat     <= 2'd0;
      step    <= 2'd0;
      hold    <= '0;
    end else begin
      pre_cnt <= o_tick ? '0 : pre_cnt + PW'(1);
      case (state)
        IDLE: begin
          if (|i_req) begin
            state   <= OWNED;
            o_grant <= 4'b0001 << win_idx;
            pat     <= i_pattern[{win_idx, 1'b0} +: 2];
            step    <= 2'd0;
            hold    <= '0;
          end
        end
        OWNED: begin
          if (!owner_req) begin
            state   <= IDLE;
            o_grant <= 4'b0000;
          end else if (higher_req && hold == HOLD_MAX) begin
            // Preemption moves straight to the new owner without an idle gap.
            o_grant <= 4'b0001 << win_idx;
            pat     <= i_pattern[{win_idx, 1'b0} +: 2];
            step    <= 2'd0;
            hold    <= '0;
          end else if (o_tick) begin
            step <= step + 2'd1;
            if (hold != HOLD_MAX) hold <= hold + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lit vector (1 = on) per pattern code; shorter sequences use the low step bits.
  always_comb begin
    lit = 2'b00;
    case (pat)
      2'd0: lit = 2'b11;
      2'd1: lit = step[0] ? 2'b10 : 2'b01;
      2'd2: begin
        case (step)
          2'd0:    lit = 2'b01;
          2'd1:    lit = 2'b11;
          2'd2:    lit = 2'b10;
          default: lit = 2'b00;
        endcase
      end
      default: lit = step[0] ? 2'b00 : 2'b11;
    endcase
  end

  assign o_LED  = (state == OWNED) ? ~lit : 2'b11;
  assign o_busy = |o_grant;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed bench for led_status_arbiter with a scoreboard of expected outputs
// (TICK_CYCLES=4, MIN_HOLD=2).
module tb_led_status_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] i_req;
  logic [7:0] i_pattern;
  logic [3:0] o_grant;
  logic       o_busy;
  logic       o_tick;
  logic [1:0] o_LED;

  typedef enum {F_GRANT, F_LED, F_BUSY, F_TICK} field_e;
  typedef struct {
    string      tag;
    field_e     f;
    logic [3:0] v;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   pc    = 0;  // bench's own view of the prescaler phase

  led_status_arbiter #(.TICK_CYCLES(4), .MIN_HOLD(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_pattern(i_pattern),
    .o_grant  (o_grant),
    .o_busy   (o_busy),
    .o_tick   (o_tick),
    .o_LED    (o_LED)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input field_e f, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.f   = f;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic push_out(input string tag, input logic [3:0] g, input logic [1:0] led);
    push({tag, "_grant"}, F_GRANT, g);
    push({tag, "_led"}, F_LED, {2'b00, led});
    push({tag, "_busy"}, F_BUSY, {3'b000, |g});
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) pc = 0;
    else pc = (pc + 1) % 4;
    #1;
  endtask

  task automatic drain();
    exp_t       e;
    logic [3:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.f)
        F_GRANT: obs = o_grant;
        F_LED:   obs = {2'b00, o_LED};
        F_BUSY:  obs = {3'b000, o_busy};
        default: obs = {3'b000, o_tick};
      endcase
      tests++;
      assert (obs === e.v) else begin
        fails++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  // Leaves the bench in the cycle where the prescaler pulses.
  task automatic to_tick_cycle();
    for (int i = 0; i < 4 && pc != 3; i++) cyc();
  endtask

  initial begin
    reset = 1'b1;
    i_req = 4'b0000;
    i_pattern = 8'h00;
    for (int i = 0; i < 3; i++) cyc();
    push_out("reset", 4'b0000, 2'b11);
    push("reset_tick", F_TICK, 4'b0000);
    drain();

    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push("idle_tick", F_TICK, {3'b000, ((pc + 1) % 4) == 3});
      push("idle_led", F_LED, 4'b0011);
      cyc();
      drain();
    end

    // Requester 2, JOHNSON: o_LED 10, 00, 01, 11, 10.
    i_pattern = 8'b00_10_00_00;
    i_req = 4'b0100;
    push_out("single_grant", 4'b0100, 2'b10);
    cyc(); drain();
    to_tick_cycle();
    push("single_pre_tick", F_LED, 4'b0010);
    drain();
    push_out("john_s1", 4'b0100, 2'b00); cyc(); drain();
    to_tick_cycle();
    push_out("john_s2", 4'b0100, 2'b01); cyc(); drain();
    to_tick_cycle();
    push_out("john_s3", 4'b0100, 2'b11); cyc(); drain();
    to_tick_cycle();
    push_out("john_s0", 4'b0100, 2'b10); cyc(); drain();
    i_req = 4'b0000;
    push_out("single_release", 4'b0000, 2'b11);
    cyc(); drain();

    // Simultaneous 1010: requester 1 (RING) wins, requester 3 waits.
    i_pattern = 8'b11_00_01_00;
    i_req = 4'b1010;
    push_out("prio_grant", 4'b0010, 2'b10);
    cyc(); drain();
    to_tick_cycle();
    push_out("prio_ring_s1", 4'b0010, 2'b01); cyc(); drain();
    to_tick_cycle();
    push_out("prio_ring_s2", 4'b0010, 2'b10); cyc(); drain();
    to_tick_cycle();
    push_out("prio_hold_sat", 4'b0010, 2'b01); cyc(); drain();

    // Owner 1 drops as requester 0 (BLINK) rises: one idle cycle first.
    i_pattern = 8'b00_00_00_11;
    i_req = 4'b1001;
    push_out("rel_gap", 4'b0000, 2'b11);
    cyc(); drain();
    push_out("rel_regrant", 4'b0001, 2'b00);
    cyc(); drain();
    i_req = 4'b0000;
    push_out("rel_idle", 4'b0000, 2'b11);
    cyc(); drain();

    // Requester 2 BLINK, requester 0 RING raised right after the grant.
    i_pattern = 8'b00_11_00_01;
    i_req = 4'b0100;
    push_out("pre_grant", 4'b0100, 2'b00);
    cyc(); drain();
    i_req = 4'b0101;
    push_out("pre_hold0", 4'b0100, 2'b00);
    cyc(); drain();
    to_tick_cycle();
    push_out("pre_hold1", 4'b0100, 2'b11); cyc(); drain();
    to_tick_cycle();
    push_out("pre_hold2", 4'b0100, 2'b00); cyc(); drain();
    push_out("pre_switch", 4'b0001, 2'b10);
    cyc(); drain();

    // Back to requester 2 BLINK, then reset mid-pattern with request held.
    i_req = 4'b0100;
    push_out("mid_gap", 4'b0000, 2'b11);
    cyc(); drain();
    push_out("mid_grant", 4'b0100, 2'b00);
    cyc(); drain();
    to_tick_cycle();
    push_out("mid_step1", 4'b0100, 2'b11); cyc(); drain();
    reset = 1'b1;
    push_out("mid_reset", 4'b0000, 2'b11);
    push("mid_reset_tick", F_TICK, 4'b0000);
    cyc(); drain();
    reset = 1'b0;
    push_out("post_reset_grant", 4'b0100, 2'b00);
    cyc(); drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
